manchester_tx: RTL and testbench

- Serialises one PA command word per write strobe into a Manchester-encoded line for the sensor front end.
- Sits directly downstream of the sequence counter and its command memory.
- The counter's write strobe pulses `wren`. The memory word at the current address arrives on `din` in the same cycle.
- Reports `busy`/`done` so the counter's `time_gap` can be checked against frame length.

---
 rtl/manchester_tx_if.sv | 30 +++
 rtl/manchester_tx.sv | 109 ++++++++++
 tb/tb_manchester_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_tx_if.sv
// Request/status bundle between the sequence counter and the Manchester transmitter.
// The counter side uses the master modport; the transmitter uses the slave modport.
interface manchester_tx_if #(
  parameter int DATA_W = 16
);
  logic              wren;
  logic [DATA_W-1:0] din;
  logic              tx_out;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output wren,
    output din,
    input  tx_out,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  wren,
    input  din,
    output tx_out,
    output busy,
    output done,
    output overrun
  );
endinterface

// File: rtl/manchester_tx.sv
// Serialises one command word per wren into an IEEE 802.3 Manchester line, MSB first.
// Define MANCHESTER_PARITY_EN to append an even-parity bit after the LSB.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line held low, waiting for wren
// SEND  | frame on the line; half_cnt times each half, bit_cnt the bit
module manchester_tx #(
  parameter int DATA_W          = 16,
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  manchester_tx_if.slave  bus
);

`ifdef MANCHESTER_PARITY_EN
  localparam int N_BITS = DATA_W + 1;
`else
  localparam int N_BITS = DATA_W;
`endif

  localparam int HALF_W = ($clog2(HALF_BIT_CYCLES + 1) < 1) ? 1 : $clog2(HALF_BIT_CYCLES + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  logic [N_BITS-1:0] shreg;
  logic [HALF_W-1:0] half_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              second_half;
  logic [N_BITS-1:0] load_word;

`ifdef MANCHESTER_PARITY_EN
  assign load_word = {bus.din, ^bus.din};
`else
  assign load_word = bus.din;
`endif

  // tx_out is computed one cycle ahead so the line itself comes straight from a flop.
  // A bit's first half is its complement and the second half its true value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      second_half <= 1'b0;
      bus.tx_out  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
      case (state)
        IDLE: begin
          bus.tx_out <= 1'b0;
          bus.busy   <= 1'b0;
          if (bus.wren) begin
            state       <= SEND;
            shreg       <= load_word;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            second_half <= 1'b0;
            bus.busy    <= 1'b1;
            bus.tx_out  <= ~load_word[N_BITS-1];
          end
        end
        SEND: begin
          bus.overrun <= bus.wren;
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + HALF_ONE;
          end else begin
            half_cnt <= '0;
            if (!second_half) begin
              second_half <= 1'b1;
              bus.tx_out  <= shreg[N_BITS-1];
            end else if (bit_cnt == BIT_LAST) begin
              state       <= IDLE;
              shreg       <= '0;
              bit_cnt     <= '0;
              second_half <= 1'b0;
              bus.tx_out  <= 1'b0;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              second_half <= 1'b0;
              shreg       <= {shreg[N_BITS-2:0], 1'b0};
              bit_cnt     <= bit_cnt + BIT_ONE;
              bus.tx_out  <= ~shreg[N_BITS-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx: table of words plus hand sequences for
// latency, back-to-back, overrun and mid-frame reset.
module tb_manchester_tx;
  localparam int DW = 16;
  localparam int H  = 2;
`ifdef MANCHESTER_PARITY_EN
  localparam int NB       = DW + 1;
  localparam int EXP_DONE = 69;
`else
  localparam int NB       = DW;
  localparam int EXP_DONE = 65;
`endif
  localparam int F = 2 * NB * H;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  head;  // first 8 line samples, earliest in bit 7
    logic        par;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  manchester_tx_if #(.DATA_W(DW)) bus ();

  manchester_tx #(.DATA_W(DW), .HALF_BIT_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NB-1:0] exp_word(input logic [15:0] d, input logic par);
`ifdef MANCHESTER_PARITY_EN
    return {d, par};
`else
    if (par === 1'bx) return '0;
    return d;
`endif
  endfunction

  function automatic logic [NB-1:0] decode(input logic [F-1:0] line, output bit ok);
    logic [NB-1:0] dec;
    logic a;
    ok  = 1'b1;
    dec = '0;
    for (int b = 0; b < NB; b++) begin
      a = line[b*2*H];
      for (int j = 0; j < H; j++) begin
        if (line[b*2*H+j] !== a) ok = 1'b0;
        if (line[b*2*H+H+j] !== ~a) ok = 1'b0;
      end
      dec[NB-1-b] = ~a;
    end
    return dec;
  endfunction

  // Called at the negedge right after the accepting edge (cycle N+1).
  task automatic capture(input int ovr_k, input logic [15:0] ovr_d,
                         output logic [F-1:0] line, output int ovr_cnt, output int ovr_pos,
                         output int busy_low, output int done_hi);
    ovr_cnt = 0; ovr_pos = 0; busy_low = 0; done_hi = 0; line = '0;
    for (int k = 1; k <= F; k++) begin
      if (k > 1) @(negedge clk);
      line[k-1] = bus.tx_out;
      if (!bus.busy) busy_low++;
      if (bus.done) done_hi++;
      if (bus.overrun) begin ovr_cnt++; ovr_pos = k; end
      if (k == ovr_k) begin bus.wren = 1'b1; bus.din = ovr_d; end
      else if (k == ovr_k + 1) bus.wren = 1'b0;
    end
  endtask

  task automatic run_vector(input vec_t v);
    logic [F-1:0]  line;
    logic [NB-1:0] dec;
    logic [7:0]    head;
    bit            ok;
    int            oc, op, bl, dh;
    bus.wren = 1'b1; bus.din = v.din;
    @(negedge clk);
    bus.wren = 1'b0;
    capture(0, '0, line, oc, op, bl, dh);
    dec = decode(line, ok);
    for (int i = 0; i < 8; i++) head[7-i] = line[i];
    check($sformatf("head_%04h", v.din), head, v.head);
    check($sformatf("decode_%04h", v.din), dec, exp_word(v.din, v.par));
    check($sformatf("encoding_%04h", v.din), ok, 1);
    check($sformatf("busy_in_frame_%04h", v.din), bl, 0);
    check($sformatf("no_early_done_%04h", v.din), dh, 0);
    check($sformatf("no_overrun_%04h", v.din), oc, 0);
    @(negedge clk);
    check($sformatf("done_pulse_%04h", v.din), bus.done, 1);
    check($sformatf("done_busy_low_%04h", v.din), bus.busy, 0);
    check($sformatf("done_tx_low_%04h", v.din), bus.tx_out, 0);
    @(negedge clk);
    check($sformatf("done_single_%04h", v.din), bus.done, 0);
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [F-1:0]  line;
    logic [NB-1:0] dec;
    bit            ok;
    int            oc, op, bl, dh, cyc, cnt_done, cnt_busy;
    logic          first_tx, first_busy;

    vecs[0] = '{din: 16'hA5C3, head: 8'b0011_1100, par: 1'b0};
    vecs[1] = '{din: 16'h0001, head: 8'b1100_1100, par: 1'b1};
    vecs[2] = '{din: 16'hFFFF, head: 8'b0011_0011, par: 1'b0};
    vecs[3] = '{din: 16'h8000, head: 8'b0011_1100, par: 1'b1};
    vecs[4] = '{din: 16'h0007, head: 8'b1100_1100, par: 1'b1};
    vecs[5] = '{din: 16'h4000, head: 8'b1100_0011, par: 1'b1};

    bus.wren = 1'b0; bus.din = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.tx_out, bus.busy, bus.done, bus.overrun}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {bus.tx_out, bus.busy, bus.done, bus.overrun}, 0);
    end

    // latency of a single frame, then a second word in the done cycle
    bus.wren = 1'b1; bus.din = 16'hA5C3;
    @(negedge clk);
    bus.wren = 1'b0;
    cyc = 1; first_tx = bus.tx_out; first_busy = bus.busy;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("first_half_msb", first_tx, 0);
    check("busy_at_n1", first_busy, 1);
    check("done_latency", cyc, EXP_DONE);
    check("done_cycle_busy", bus.busy, 0);
    check("done_cycle_tx", bus.tx_out, 0);
    bus.wren = 1'b1; bus.din = 16'h0001;
    @(negedge clk);
    bus.wren = 1'b0;
    check("b2b_no_overrun", bus.overrun, 0);
    check("b2b_busy", bus.busy, 1);
    capture(0, '0, line, oc, op, bl, dh);
    dec = decode(line, ok);
    check("b2b_decode", dec, exp_word(16'h0001, 1'b1));
    check("b2b_encoding", ok, 1);
    check("b2b_lsb_halves", {line[(DW-1)*2*H], line[(DW-1)*2*H+H]}, 2'b01);
    check("b2b_no_overrun_frame", oc, 0);
    @(negedge clk);
    check("b2b_done", bus.done, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // overrun: second request ten cycles into the frame
    bus.wren = 1'b1; bus.din = 16'h5A3C;
    @(negedge clk);
    bus.wren = 1'b0;
    capture(10, 16'hFFFF, line, oc, op, bl, dh);
    dec = decode(line, ok);
    check("ovr_count", oc, 1);
    check("ovr_position", op, 11);
    check("ovr_word_intact", dec, exp_word(16'h5A3C, 1'b0));
    check("ovr_encoding", ok, 1);
    check("ovr_busy", bl, 0);
    @(negedge clk);
    check("ovr_done", bus.done, 1);
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < F + 4; i++) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("ovr_single_done", cnt_done, 0);
    check("ovr_no_second_frame", cnt_busy, 0);

    // reset in the middle of a frame
    bus.wren = 1'b1; bus.din = 16'hFFFF;
    @(negedge clk);
    bus.wren = 1'b0;
    repeat (19) @(negedge clk);
    check("midrst_busy_before", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_async_outputs", {bus.tx_out, bus.busy}, 0);
    cnt_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
    end
    rst_n = 1'b1;
    cnt_busy = 0;
    for (int i = 0; i < F + 5; i++) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("midrst_no_done", cnt_done, 0);
    check("midrst_stays_idle", cnt_busy, 0);
    run_vector(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
